// File: rtl/conv_pkg.sv
// Shared state encoding, default sizes and accumulator sizing helper for the
// convolution MAC engine.
package conv_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_KERNEL_LEN = 8;
  localparam int unsigned DEF_OUT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    MAC  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } conv_mac_state_t;

  // Full-precision sum of k products of two dw-bit unsigned values.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned k);
    return (2 * dw) + int'($clog2(k));
  endfunction

endpackage

// File: rtl/conv_sample_window.sv
// Sliding sample window: KERNEL_LEN-deep shift register with synchronous
// clear and a single indexed read port.
module conv_sample_window
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned KERNEL_LEN = DEF_KERNEL_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          shift_en,
  input  logic [DATA_WIDTH-1:0]         shift_in,
  input  logic [$clog2(KERNEL_LEN)-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  logic [DATA_WIDTH-1:0] win_q [KERNEL_LEN];

  // Newest sample enters at tap 0; older samples move toward tap K-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < KERNEL_LEN; k++) win_q[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < KERNEL_LEN; k++) win_q[k] <= '0;
    end else if (shift_en) begin
      win_q[0] <= shift_in;
      for (int k = 1; k < KERNEL_LEN; k++) win_q[k] <= win_q[k-1];
    end
  end

  assign rd_data = win_q[rd_idx];

endmodule

// File: rtl/conv_mac_engine.sv
// Sequential FIR convolution engine feeding the result register; one tap per
// cycle, auto zero-flush for N+K-1 outputs. CONV_MAC_SAT_EN adds saturation + sat_flag.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned KERNEL_LEN = DEF_KERNEL_LEN,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coef_we,
  input  logic [$clog2(KERNEL_LEN)-1:0] coef_addr,
  input  logic [DATA_WIDTH-1:0]         coef_data,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_last,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_en,
  output logic                          out_clr,
  output logic                          busy,
`ifdef CONV_MAC_SAT_EN
  output logic                          sat_flag,
`endif
  output logic                          done
);

  localparam int unsigned TAP_W  = $clog2(KERNEL_LEN);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, KERNEL_LEN);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KERNEL_LEN - 1);

  conv_mac_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] coef_q [KERNEL_LEN];
  logic [TAP_W-1:0]      tap_q, tap_d;
  logic [TAP_W-1:0]      flush_q, flush_d;
  logic [ACC_W-1:0]      acc_q, acc_d, acc_next;
  logic [PROD_W-1:0]     prod;
  logic                  last_q, last_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_en_q, out_en_d;
  logic                  out_clr_q, out_clr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sat_q, sat_d;

  logic                  win_clr, win_shift;
  logic [DATA_WIDTH-1:0] win_in, win_rd, coef_rd;

  conv_sample_window #(
    .DATA_WIDTH (DATA_WIDTH),
    .KERNEL_LEN (KERNEL_LEN)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .clr      (win_clr),
    .shift_en (win_shift),
    .shift_in (win_in),
    .rd_idx   (tap_q),
    .rd_data  (win_rd)
  );

  assign coef_rd  = coef_q[tap_q];
  assign prod     = PROD_W'(coef_rd) * PROD_W'(win_rd);
  assign acc_next = acc_q + ACC_W'(prod);

  // Coefficient bank: writable only while idle, and a coincident start wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < KERNEL_LEN; k++) coef_q[k] <= '0;
    end else if (state_q == IDLE && coef_we && !start && (32'(coef_addr) < KERNEL_LEN)) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (in_valid && in_ready_q) state_d = MAC;
      MAC:  if (tap_q == TAP_LAST) state_d = OUT;
      OUT: begin
        if (!last_q)                  state_d = RUN;
        else if (flush_q == TAP_LAST) state_d = DONE;
        else                          state_d = MAC;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and strobes; strobes decode the upcoming state so they are registered.
  always_comb begin
    tap_d      = tap_q;
    flush_d    = flush_q;
    acc_d      = acc_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    sat_d      = 1'b0;
    win_clr    = 1'b0;
    win_shift  = 1'b0;
    win_in     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          win_clr = 1'b1;
          flush_d = '0;
          last_d  = 1'b0;
        end
      end
      RUN: begin
        if (in_valid && in_ready_q) begin
          win_shift = 1'b1;
          win_in    = in_data;
          acc_d     = '0;
          tap_d     = '0;
          last_d    = in_last;
        end
      end
      MAC: begin
        acc_d = acc_next;
        tap_d = tap_q + TAP_W'(1);
        if (tap_q == TAP_LAST) begin
          out_data_d = OUT_WIDTH'(acc_next);
`ifdef CONV_MAC_SAT_EN
          if ((acc_next >> OUT_WIDTH) != '0) begin
            out_data_d = '1;
            sat_d      = 1'b1;
          end
`endif
        end
      end
      OUT: begin
        // Zero-flush: push a zero sample without any input handshake.
        if (last_q && flush_q != TAP_LAST) begin
          win_shift = 1'b1;
          flush_d   = flush_q + TAP_W'(1);
          acc_d     = '0;
          tap_d     = '0;
        end
      end
      default: ;
    endcase
    in_ready_d = (state_d == RUN);
    out_en_d   = (state_d == OUT);
    out_clr_d  = (state_q == IDLE) && start;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q      <= '0;
      flush_q    <= '0;
      acc_q      <= '0;
      last_q     <= 1'b0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
      in_ready_q <= 1'b0;
      out_en_q   <= 1'b0;
      out_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tap_q      <= tap_d;
      flush_q    <= flush_d;
      acc_q      <= acc_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
      in_ready_q <= in_ready_d;
      out_en_q   <= out_en_d;
      out_clr_q  <= out_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = out_data_q;
  assign out_en   = out_en_q;
  assign out_clr  = out_clr_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef CONV_MAC_SAT_EN
  assign sat_flag = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
- Sequential FIR-style convolution engine for the convolutional coprocessor; sits directly upstream of the 8x32 result register.
- Streams DATA_WIDTH-bit samples through a KERNEL_LEN-deep sliding window.
- Computes one product per cycle against a coefficient bank, then presents each result together with the enable/clear strobes that drive the result register.
- Auto-flushes with zeros after the last sample to produce the full N+K-1 output sequence.

Parameters:
- DATA_WIDTH, 8, sample and coefficient width (unsigned).
- KERNEL_LEN, 8, number of taps; must be ≥ 2.
- OUT_WIDTH, 16, width of out_data delivered to the result register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- coef_we  in  1  coefficient write strobe; honoured only in IDLE.
- coef_addr  in  $clog2(KERNEL_LEN)  tap index.
- coef_data  in  DATA_WIDTH  coefficient value.
- start  in  1  begin a new stream; honoured only in IDLE.
- in_valid  in  1  sample valid.
- in_ready  out  1  engine can accept a sample.
- in_data  in  DATA_WIDTH  sample.
- in_last  in  1  marks final sample of the stream; qualified by the handshake.
- out_data  out  OUT_WIDTH  convolution result; drives register d_in.
- out_en  out  1  one-cycle load strobe; drives register enh.
- out_clr  out  1  one-cycle clear strobe; drives register clrh.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the final flushed output.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - Window, coefficient bank, accumulator, tap counter, flush counter and out_data are all cleared to 0.
  - in_ready, out_en, out_clr, busy and done go to 0.
  - Reset mid-stream discards all work; no output is emitted.
- States: IDLE, RUN, MAC, OUT, DONE.
- IDLE:
  - coef_we writes coef[coef_addr] each cycle.
  - start takes priority over coef_we in the same cycle; the write is dropped.
  - On start: window cleared to 0, flush counter cleared, out_clr=1 in the next cycle, go to RUN.
- RUN:
  - in_ready=1.
  - On in_valid&in_ready: window shifts (win[0]←in_data, win[k]←win[k-1]), accumulator cleared, tap counter set to 0, go to MAC.
  - If in_last is set, a last flag is recorded.
- MAC:
  - KERNEL_LEN cycles, one per tap k = 0..K-1: acc += coef[k]*win[k].
  - Product width is 2*DATA_WIDTH; ACC_WIDTH = 2*DATA_WIDTH+$clog2(KERNEL_LEN), so the accumulator never overflows.
  - Go to OUT after tap K-1.
- OUT (one cycle):
  - out_en=1; out_data is updated on the edge entering OUT and held until the next OUT.
  - Without the last flag set: return to RUN.
  - With the last flag set and flush count < K-1: internally shift 0 into the window, increment the flush count, go to MAC. No handshake in this path; in_ready stays 0.
  - With flush count == K-1: go to DONE.
- DONE (one cycle): done=1, then IDLE.
- Latency: a sample accepted at edge T gives out_en high in cycle T+K+1; in_ready is high again at T+K+2. Throughput is 1 sample per K+2 cycles.
- Ignored inputs:
  - in_valid outside RUN.
  - start and coef_we outside IDLE.
- in_valid held low in RUN: the engine waits indefinitely, with no timeout.
- Output mapping: out_data = acc[OUT_WIDTH-1:0] (truncation; zero-extended if ACC_WIDTH < OUT_WIDTH).
- Coefficients persist across streams until rewritten or reset.

Optional Feature:
- Macro: CONV_MAC_SAT_EN.
- Defined: if acc > 2^OUT_WIDTH-1, out_data = all ones (unsigned saturation). An extra output port sat_flag (1 bit) pulses with out_en whenever clamping occurred; reset value 0.
- Undefined: plain truncation as above; the sat_flag port does not exist.

Decomposition:
- Package conv_pkg:
  - state enum conv_mac_state_t {IDLE, RUN, MAC, OUT, DONE};
  - function acc_width(dw, k);
  - localparam defaults for DATA_WIDTH, KERNEL_LEN and OUT_WIDTH.
- One sub-module, conv_sample_window: KERNEL_LEN×DATA_WIDTH shift register with clr, shift_en, shift_in and an indexed read port. Same clk/rst conventions.

Test Plan:
- Reset mid-MAC (assert rst during the 3rd MAC cycle):
  - All outputs go to 0 immediately.
  - No out_en follows.
  - After release, the coefficient bank reads as 0; a new stream of sample 5 yields out_data 0.
- Unity kernel (K=8, all coef=1), samples 1,2,3 with in_last on 3:
  - out_clr pulse first.
  - Exactly 10 out_en pulses with out_data 1,3,6,6,6,6,6,6,5,3.
  - Then one done pulse; busy falls.
- Timing check:
  - Sample accepted at cycle T gives out_en at exactly T+9 (K=8).
  - in_ready low from T+1 through T+9 and high at T+10.
  - A second start during busy has no effect.
- Coefficient isolation:
  - coef[0]=3 and others 0, stream 7,9(last): outputs 21,27 then seven 0s.
  - A coef_we issued during RUN does not change the results.
  - Asserting start together with coef_we in IDLE drops the write.
- Overflow (all coef=255, eight samples of 255, last on 8th):
  - 1st output 65025.
  - 8th output 61448 without CONV_MAC_SAT_EN.
  - 8th output 65535 with CONV_MAC_SAT_EN, and sat_flag=1 on that out_en.
- Back-to-back streams: a second start after done gives a fresh out_clr and a cleared window; the first output of the second stream depends only on its own first sample.
